// File: rtl/dmem_arbiter.sv
// Arbiter sharing the data_memory port between the CPU MEM stage and a debug/loader port.
// Optional grant counters are built in when DMEM_ARB_STATS_EN is defined.
//
// state     | meaning
// ST_IDLE   | no access in flight, arbitrate between cpu_req_i and dbg_req_i
// ST_CPU    | CPU access in flight, counting wait states
// ST_DBG    | debug access in flight, counting wait states
module dmem_arbiter #(
   parameter int WAIT_STATES    = 0,
   parameter int MAX_CPU_STREAK = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cpu_req_i,
   input  logic        cpu_write_i,
   input  logic        cpu_byte_en_i,
   input  logic [15:0] cpu_addr_i,
   input  logic [15:0] cpu_wdata_i,
   output logic [15:0] cpu_rdata_o,
   output logic        cpu_stall_o,
   input  logic        dbg_req_i,
   input  logic        dbg_write_i,
   input  logic        dbg_byte_en_i,
   input  logic [15:0] dbg_addr_i,
   input  logic [15:0] dbg_wdata_i,
   output logic [15:0] dbg_rdata_o,
   output logic        dbg_ack_o,
   output logic        mem_write_o,
   output logic        mem_byte_en_o,
   output logic [15:0] mem_addr_o,
   output logic [15:0] mem_wdata_o,
   input  logic [15:0] mem_rdata_i
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0] cpu_grant_cnt_o,
   output logic [15:0] dbg_grant_cnt_o
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_CPU, ST_DBG} state_t;

   localparam logic [3:0] WAIT_C   = 4'(WAIT_STATES);
   localparam logic [7:0] STREAK_C = 8'(MAX_CPU_STREAK);

   state_t      state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic [7:0]  streak_q, streak_d;
   logic [15:0] dbg_rdata_q, dbg_rdata_d;
   logic        dbg_ack_q, dbg_ack_d;

   logic done;
   logic dbg_pend;
   logic cpu_grant;
   logic dbg_grant;

   // A request still held high during its own ack cycle must not start a second access.
   assign dbg_pend  = dbg_req_i && !dbg_ack_q;
   assign done      = (state_q != ST_IDLE) && (wcnt_q == WAIT_C);
   assign cpu_grant = (state_q == ST_IDLE) && cpu_req_i && !(dbg_pend && (streak_q >= STREAK_C));
   assign dbg_grant = (state_q == ST_IDLE) && dbg_pend && (!cpu_req_i || (streak_q >= STREAK_C));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         wcnt_q      <= '0;
         streak_q    <= '0;
         dbg_rdata_q <= '0;
         dbg_ack_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         streak_q    <= streak_d;
         dbg_rdata_q <= dbg_rdata_d;
         dbg_ack_q   <= dbg_ack_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wcnt_d      = '0;
      streak_d    = streak_q;
      dbg_rdata_d = dbg_rdata_q;
      dbg_ack_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cpu_grant)      state_d = ST_CPU;
            else if (dbg_grant) state_d = ST_DBG;
         end
         ST_CPU, ST_DBG: begin
            if (done) state_d = ST_IDLE;
            else      wcnt_d  = wcnt_q + 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase
      if (dbg_grant || !dbg_req_i)
         streak_d = '0;
      else if (cpu_grant && dbg_pend && (streak_q != 8'hFF))
         streak_d = streak_q + 8'd1;
      if ((state_q == ST_DBG) && done) begin
         dbg_ack_d   = 1'b1;
         dbg_rdata_d = dbg_write_i ? 16'h0000 : mem_rdata_i;
      end
   end

   always_comb begin
      mem_write_o   = 1'b0;
      mem_byte_en_o = 1'b0;
      mem_addr_o    = '0;
      mem_wdata_o   = '0;
      cpu_rdata_o   = '0;
      case (state_q)
         ST_CPU: begin
            mem_write_o   = cpu_write_i && done;
            mem_byte_en_o = cpu_byte_en_i;
            mem_addr_o    = cpu_addr_i;
            mem_wdata_o   = cpu_wdata_i;
            cpu_rdata_o   = mem_rdata_i;
         end
         ST_DBG: begin
            mem_write_o   = dbg_write_i && done;
            mem_byte_en_o = dbg_byte_en_i;
            mem_addr_o    = dbg_addr_i;
            mem_wdata_o   = dbg_wdata_i;
         end
         default: ;
      endcase
      // Held low during reset so the pipeline sees a quiet port regardless of cpu_req_i.
      cpu_stall_o = rst_ni && cpu_req_i && !((state_q == ST_CPU) && done);
   end

   assign dbg_rdata_o = dbg_rdata_q;
   assign dbg_ack_o   = dbg_ack_q;

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] cpu_cnt_q, dbg_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cpu_cnt_q <= '0;
         dbg_cnt_q <= '0;
      end else begin
         if (cpu_grant) cpu_cnt_q <= cpu_cnt_q + 16'd1;
         if (dbg_grant) dbg_cnt_q <= dbg_cnt_q + 16'd1;
      end
   end

   assign cpu_grant_cnt_o = cpu_cnt_q;
   assign dbg_grant_cnt_o = dbg_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances (WAIT_STATES 0, 2, 3) share stimulus,
// each with its own memory model.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        cpu_req, cpu_write, cpu_byte_en;
   logic [15:0] cpu_addr, cpu_wdata;
   logic        dbg_req, dbg_write, dbg_byte_en;
   logic [15:0] dbg_addr, dbg_wdata;

   logic [15:0] cpu_rdata [3];
   logic        cpu_stall [3];
   logic [15:0] dbg_rdata [3];
   logic        dbg_ack   [3];
   logic        mem_write [3];
   logic        mem_byte_en [3];
   logic [15:0] mem_addr  [3];
   logic [15:0] mem_wdata [3];
   logic [15:0] mem_rdata [3];
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] cpu_gcnt [3];
   logic [15:0] dbg_gcnt [3];
`endif

   logic [15:0] mem [3][256];
   logic        pre_we = 1'b0;
   int          pre_k  = 0;
   logic [7:0]  pre_idx = '0;
   logic [15:0] pre_data = '0;
   int          wr_cnt2 = 0;

   int err_cnt = 0;
   int chk_cnt = 0;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      dmem_arbiter #(
         .WAIT_STATES   ((k == 0) ? 0 : (k == 1) ? 2 : 3),
         .MAX_CPU_STREAK(4)
      ) u_dut (
         .clk_i        (clk),
         .rst_ni       (rst_n),
         .cpu_req_i    (cpu_req),
         .cpu_write_i  (cpu_write),
         .cpu_byte_en_i(cpu_byte_en),
         .cpu_addr_i   (cpu_addr),
         .cpu_wdata_i  (cpu_wdata),
         .cpu_rdata_o  (cpu_rdata[k]),
         .cpu_stall_o  (cpu_stall[k]),
         .dbg_req_i    (dbg_req),
         .dbg_write_i  (dbg_write),
         .dbg_byte_en_i(dbg_byte_en),
         .dbg_addr_i   (dbg_addr),
         .dbg_wdata_i  (dbg_wdata),
         .dbg_rdata_o  (dbg_rdata[k]),
         .dbg_ack_o    (dbg_ack[k]),
         .mem_write_o  (mem_write[k]),
         .mem_byte_en_o(mem_byte_en[k]),
         .mem_addr_o   (mem_addr[k]),
         .mem_wdata_o  (mem_wdata[k]),
         .mem_rdata_i  (mem_rdata[k])
`ifdef DMEM_ARB_STATS_EN
         ,
         .cpu_grant_cnt_o(cpu_gcnt[k]),
         .dbg_grant_cnt_o(dbg_gcnt[k])
`endif
      );

      assign mem_rdata[k] = mem[k][mem_addr[k][8:1]];

      always @(posedge clk) begin
         if (pre_we && pre_k == k)
            mem[k][pre_idx] <= pre_data;
         else if (mem_write[k]) begin
            if (!mem_byte_en[k])
               mem[k][mem_addr[k][8:1]] <= mem_wdata[k];
            else if (mem_addr[k][0])
               mem[k][mem_addr[k][8:1]][15:8] <= mem_wdata[k][7:0];
            else
               mem[k][mem_addr[k][8:1]][7:0] <= mem_wdata[k][7:0];
         end
      end
   end

   always @(posedge clk) if (mem_write[2]) wr_cnt2 <= wr_cnt2 + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_req = 0; cpu_write = 0; cpu_byte_en = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_write = 0; dbg_byte_en = 0; dbg_addr = '0; dbg_wdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
      tick();
   endtask

   task automatic preload(input int k, input logic [7:0] idx, input logic [15:0] d);
      pre_k = k; pre_idx = idx; pre_data = d; pre_we = 1;
      tick();
      pre_we = 0;
   endtask

   task automatic cpu_access(input logic [15:0] a);
      int n;
      cpu_req = 1; cpu_write = 0; cpu_addr = a;
      #1;
      n = 0;
      while (cpu_stall[0] && n < 20) begin tick(); n++; end
      if (n >= 20) chk("cpu_acc_timeout", 0, 1);
      tick();
      cpu_req = 0;
   endtask

   task automatic dbg_access(input logic [15:0] a);
      int n;
      dbg_req = 1; dbg_write = 0; dbg_addr = a;
      n = 0;
      while (!dbg_ack[0] && n < 20) begin tick(); n++; end
      if (n >= 20) chk("dbg_acc_timeout", 0, 1);
      dbg_req = 0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, wrs, ng, base;
      logic g [16];

      idle_inputs();
      rst_n = 0;
      cpu_req = 1;
      tick();
      chk("rst_mem_write", mem_write[0], 0);
      chk("rst_mem_addr",  mem_addr[0], 0);
      chk("rst_cpu_stall", cpu_stall[0], 0);
      chk("rst_cpu_rdata", cpu_rdata[0], 0);
      chk("rst_dbg_ack",   dbg_ack[0], 0);
      chk("rst_dbg_rdata", dbg_rdata[0], 0);
      do_reset();

      // Reset in the middle of a 3-wait-state store.
      preload(2, 8'd8, 16'h5555);
      cpu_req = 1; cpu_write = 1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
      #1;
      chk("rw_idle_stall", cpu_stall[2], 1);
      base = wr_cnt2;
      tick();
      chk("rw_w0_addr",  mem_addr[2], 16'h0010);
      chk("rw_w0_write", mem_write[2], 0);
      chk("rw_w0_stall", cpu_stall[2], 1);
      tick();
      chk("rw_w1_write", mem_write[2], 0);
      rst_n = 0;
      #1;
      chk("rw_rst_write", mem_write[2], 0);
      chk("rw_rst_addr",  mem_addr[2], 0);
      chk("rw_rst_wdata", mem_wdata[2], 0);
      chk("rw_rst_stall", cpu_stall[2], 0);
      chk("rw_rst_rdata", cpu_rdata[2], 0);
      chk("rw_rst_ack",   dbg_ack[2], 0);
      tick(); tick(); tick();
      cpu_req = 0; cpu_write = 0;
      rst_n = 1;
      tick(); tick(); tick(); tick();
      chk("rw_no_pulse", wr_cnt2 - base, 0);
      chk("rw_mem_kept", mem[2][8], 16'h5555);

      // CPU load, zero wait states.
      do_reset();
      preload(0, 8'd16, 16'h1234);
      cpu_req = 1; cpu_write = 0; cpu_addr = 16'h0020;
      #1;
      chk("ld_stall_c0", cpu_stall[0], 1);
      chk("ld_rdata_c0", cpu_rdata[0], 0);
      tick();
      chk("ld_stall_c1", cpu_stall[0], 0);
      chk("ld_rdata_c1", cpu_rdata[0], 16'h1234);
      chk("ld_write_c1", mem_write[0], 0);
      tick();
      cpu_req = 0;
      #1;
      chk("ld_idle_addr", mem_addr[0], 0);

      // Debug write then read, two wait states.
      do_reset();
      dbg_req = 1; dbg_write = 1; dbg_addr = 16'h0040; dbg_wdata = 16'hA5A5;
      n = 0; wrs = 0;
      while (!dbg_ack[1] && n < 20) begin
         tick(); n++;
         if (mem_write[1]) wrs++;
      end
      chk("dw_ack_lat", n, 4);
      chk("dw_pulses",  wrs, 1);
      dbg_req = 0; dbg_write = 0; dbg_wdata = '0;
      tick();
      chk("dw_ack_width", dbg_ack[1], 0);
      chk("dw_mem", mem[1][32], 16'hA5A5);
      dbg_req = 1;
      n = 0; wrs = 0;
      while (!dbg_ack[1] && n < 20) begin
         tick(); n++;
         if (mem_write[1]) wrs++;
      end
      chk("dr_ack_lat", n, 4);
      chk("dr_pulses",  wrs, 0);
      chk("dr_rdata",   dbg_rdata[1], 16'hA5A5);
      dbg_req = 0;
      tick(); tick();
      chk("dr_rdata_held", dbg_rdata[1], 16'hA5A5);
      chk("dr_ack_low",    dbg_ack[1], 0);

      // CPU byte store to odd address.
      do_reset();
      preload(0, 8'd24, 16'h0000);
      cpu_req = 1; cpu_write = 1; cpu_byte_en = 1; cpu_addr = 16'h0031; cpu_wdata = 16'h00FF;
      #1;
      chk("bs_stall_c0", cpu_stall[0], 1);
      tick();
      chk("bs_write",   mem_write[0], 1);
      chk("bs_byte_en", mem_byte_en[0], 1);
      chk("bs_addr",    mem_addr[0], 16'h0031);
      chk("bs_wdata",   mem_wdata[0], 16'h00FF);
      chk("bs_stall",   cpu_stall[0], 0);
      tick();
      cpu_req = 0; cpu_write = 0; cpu_byte_en = 0;
      #1;
      chk("bs_mem", mem[0][24], 16'hFF00);

      // Anti-starvation: CPU always requesting, debug requester drops dbg_req on ack.
      do_reset();
      cpu_req = 1; cpu_addr = 16'h0100;
      dbg_req = 1; dbg_addr = 16'h0200;
      ng = 0;
      for (int c = 0; c < 40 && ng < 12; c++) begin
         tick();
         if (mem_addr[0] == 16'h0100) begin g[ng] = 1'b0; ng++; end
         else if (mem_addr[0] == 16'h0200) begin g[ng] = 1'b1; ng++; end
         dbg_req = !dbg_ack[0];
      end
      if (ng < 11) chk("as_grant_count", ng, 11);
      else begin
         chk("as_g0", g[0], 0);
         chk("as_g1", g[1], 0);
         chk("as_g2", g[2], 0);
         chk("as_g3", g[3], 0);
         chk("as_g4", g[4], 1);
         chk("as_g5", g[5], 0);
         chk("as_g9", g[9], 0);
         chk("as_g10", g[10], 1);
      end

`ifdef DMEM_ARB_STATS_EN
      do_reset();
      cpu_access(16'h0002);
      dbg_access(16'h0004);
      cpu_access(16'h0006);
      dbg_access(16'h0008);
      cpu_access(16'h000A);
      tick();
      chk("st_cpu_cnt", cpu_gcnt[0], 3);
      chk("st_dbg_cnt", dbg_gcnt[0], 2);
`endif

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
